// File: rtl/pwm_deserializer.sv
// pwm_deserializer
// Measures an incoming PWM line and recovers its duty cycle as an integer
// percentage 0..99, using floor(100*H/P) where H is high time and P is period
// (both in clk cycles, measured rise to rise on the synchronized line).
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   pwm_in     - asynchronous PWM line (synchronized internally)
//   duty_cycle - last recovered duty, 0..99
//   duty_valid - one-cycle strobe whenever duty_cycle updates
//   stuck      - no edge for TIMEOUT cycles; duty_cycle shows the stuck level
//   overrun    - sticky: a period completed while the divider was still busy
module pwm_deserializer #(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [6:0] duty_cycle,
    output logic       duty_valid,
    output logic       stuck,
    output logic       overrun
);

    localparam int N  = CNT_W + 7;
    localparam int IW = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IW-1:0]    IT_LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    // 100*h as (h<<6)+(h<<5)+(h<<2), widened so nothing is lost
    function automatic logic [N-1:0] mul100(input logic [CNT_W-1:0] h);
        logic [N-1:0] e;
        e = {7'b0, h};
        return (e << 6) + (e << 5) + (e << 2);
    endfunction

    logic              sync_1, sync_2, sync_3;
    logic [1:0]        warm;
    state_t            state, state_next;
    logic [CNT_W-1:0]  h_cnt, p_cnt, since_cnt;
    logic              cnt_clear, capture, timeout_fire;
    logic              armed, rise, fall;

    logic              div_busy;
    logic [IW-1:0]     div_it;
    logic [CNT_W-1:0]  div_rem, div_den;
    logic [N-1:0]      div_quo;
    logic              div_last, div_accept;
    logic [CNT_W:0]    trial;
    logic              trial_ge;
    logic [CNT_W-1:0]  rem_next;
    logic [N-1:0]      quo_next;

    // Edges are ignored until the synchronizer chain has refilled after reset,
    // so a line that is already high at release does not fake a rise.
    assign armed = (warm == 2'd3);
    assign rise  = armed & sync_2 & ~sync_3;
    assign fall  = armed & ~sync_2 & sync_3;

    // Synchronizer, edge-detect flop and post-reset warm-up counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
            warm   <= 2'd0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state; an edge always beats a timeout on the same cycle
    always_comb begin
        state_next   = state;
        cnt_clear    = 1'b0;
        capture      = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_clear  = 1'b1;
                    state_next = HIGH;
                end else begin
                    state_next = IDLE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_next = LOW;
                end else if (since_cnt == TO_LAST) begin
                    timeout_fire = 1'b1;
                    state_next   = IDLE;
                end else begin
                    state_next = HIGH;
                end
            end
            LOW: begin
                if (rise) begin
                    capture    = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = HIGH;
                end else if (since_cnt == TO_LAST) begin
                    timeout_fire = 1'b1;
                    state_next   = IDLE;
                end else begin
                    state_next = LOW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // High-time, period and edge-age counters. The rise cycle itself is not
    // counted into p_cnt, so the captured period is p_cnt + 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            p_cnt     <= '0;
            since_cnt <= '0;
        end else begin
            if (cnt_clear) begin
                h_cnt <= '0;
                p_cnt <= '0;
            end else if (state == HIGH) begin
                h_cnt <= h_cnt + CNT_W'(1);
                if (p_cnt != CNT_MAX) p_cnt <= p_cnt + CNT_W'(1);
            end else if (state == LOW) begin
                if (p_cnt != CNT_MAX) p_cnt <= p_cnt + CNT_W'(1);
            end
            if (rise || fall || timeout_fire || state == IDLE) since_cnt <= '0;
            else                                               since_cnt <= since_cnt + CNT_W'(1);
        end
    end

    // The final iteration and the result write share a clock edge; a capture
    // landing on that same cycle is accepted.
    assign div_last   = div_busy && (div_it == IT_LAST);
    assign div_accept = capture && (!div_busy || div_last);

    // One restoring-division step: quotient bits shift in as dividend bits shift out
    always_comb begin
        trial    = {div_rem, div_quo[N-1]};
        trial_ge = (trial >= {1'b0, div_den});
        if (trial_ge) rem_next = trial[CNT_W-1:0] - div_den;
        else          rem_next = trial[CNT_W-1:0];
        quo_next = {div_quo[N-2:0], trial_ge};
    end

    // Divider datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_busy <= 1'b0;
            div_it   <= '0;
            div_rem  <= '0;
            div_den  <= '0;
            div_quo  <= '0;
        end else if (div_accept) begin
            div_busy <= 1'b1;
            div_it   <= '0;
            div_rem  <= '0;
            div_den  <= p_cnt + CNT_W'(1);
            div_quo  <= mul100(h_cnt);
        end else if (div_busy) begin
            div_rem <= rem_next;
            div_quo <= quo_next;
            div_it  <= div_it + IW'(1);
            if (div_last) div_busy <= 1'b0;
        end
    end

    // Registered status outputs; a timeout reports the level the line is stuck at
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_cycle <= 7'd0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (timeout_fire) begin
                duty_cycle <= sync_2 ? 7'd99 : 7'd0;
                duty_valid <= 1'b1;
                stuck      <= 1'b1;
            end else if (div_last) begin
                duty_cycle <= (quo_next > N'(99)) ? 7'd99 : quo_next[6:0];
                duty_valid <= 1'b1;
                stuck      <= 1'b0;
            end
            if (capture && !div_accept) overrun <= 1'b1;
        end
    end

endmodule
